// File: rtl/order_sort_pkg.sv
// ============================================================================
//  order_sort_pkg
//  Shared helpers for the group orderer: log2, stage count, direction codes
//  and lane slice addressing.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package order_sort_pkg;

    localparam logic ASC  = 1'b0;
    localparam logic DESC = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // A bitonic network over 2**lg lanes has lg*(lg+1)/2 compare-exchange columns.
    function automatic int stages(input int group);
        int lg;
        lg = clog2(group);
        return lg * (lg + 1) / 2;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/order_group_sorter.sv
// ============================================================================
//  order_group_sorter
//  Fully pipelined bitonic sorter for one GROUP-lane slice, with the beat's
//  valid and direction bits carried through every stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module order_group_sorter
    import order_sort_pkg::*;
#(
    parameter int DSIZE = 64,
    parameter int KSIZE = 64,
    parameter int GROUP = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hold,
    input  logic                     in_valid,
    input  logic                     in_desc,
    input  logic [GROUP*DSIZE-1:0]   in_data,
    output logic                     out_valid,
    output logic                     out_desc,
    output logic [GROUP*DSIZE-1:0]   out_data
);

    localparam int c_lg     = clog2(GROUP);
    localparam int c_stages = stages(GROUP);

    logic [DSIZE-1:0]    r_data [c_stages][GROUP];
    logic [c_stages-1:0] r_valid;
    logic [c_stages-1:0] r_desc;

    logic [DSIZE-1:0]    w_src  [c_stages][GROUP];
    logic [DSIZE-1:0]    w_next [c_stages][GROUP];
    logic [c_stages-1:0] w_src_valid;
    logic [c_stages-1:0] w_src_desc;

    for (genvar S = 0; S < c_stages; S++) begin : g_src
        if (S == 0) begin : g_head
            assign w_src_valid[S] = in_valid;
            assign w_src_desc[S]  = in_desc;
            for (genvar L = 0; L < GROUP; L++) begin : g_lane
                assign w_src[S][L] = in_data[lane_lo(L, DSIZE) +: DSIZE];
            end
        end else begin : g_link
            assign w_src_valid[S] = r_valid[S-1];
            assign w_src_desc[S]  = r_desc[S-1];
            for (genvar L = 0; L < GROUP; L++) begin : g_lane
                assign w_src[S][L] = r_data[S-1][L];
            end
        end
    end

    // Merge phase K builds sorted runs of 2**K; step T compares at distance 2**(K-1-T).
    for (genvar K = 1; K <= c_lg; K++) begin : g_merge
        for (genvar T = 0; T < K; T++) begin : g_step
            localparam int c_s = K * (K - 1) / 2 + T;
            localparam int c_d = 1 << (K - 1 - T);
            for (genvar I = 0; I < GROUP; I++) begin : g_lane
                localparam int c_p = I ^ c_d;
                if (c_p > I) begin : g_cmp
                    localparam logic c_blk = ((I & (1 << K)) != 0) ? DESC : ASC;
                    logic             w_dir;
                    logic             w_swap;
                    logic [KSIZE-1:0] w_key_lo;
                    logic [KSIZE-1:0] w_key_hi;

                    assign w_key_lo = w_src[c_s][I][DSIZE-1 -: KSIZE];
                    assign w_key_hi = w_src[c_s][c_p][DSIZE-1 -: KSIZE];
                    assign w_dir    = c_blk ^ w_src_desc[c_s];
                    // Strict compares: equal keys stay where they are.
                    assign w_swap   = (w_dir == DESC) ? (w_key_lo < w_key_hi)
                                                      : (w_key_lo > w_key_hi);
                    assign w_next[c_s][I]   = w_swap ? w_src[c_s][c_p] : w_src[c_s][I];
                    assign w_next[c_s][c_p] = w_swap ? w_src[c_s][I]   : w_src[c_s][c_p];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_desc  <= '0;
            for (int s = 0; s < c_stages; s++) begin
                for (int l = 0; l < GROUP; l++) begin
                    r_data[s][l] <= '0;
                end
            end
        end else if (!hold) begin
            r_valid <= w_src_valid;
            r_desc  <= w_src_desc;
            for (int s = 0; s < c_stages; s++) begin
                for (int l = 0; l < GROUP; l++) begin
                    r_data[s][l] <= w_next[s][l];
                end
            end
        end
    end

    assign out_valid = r_valid[c_stages-1];
    assign out_desc  = r_desc[c_stages-1];

    for (genvar L = 0; L < GROUP; L++) begin : g_out
        assign out_data[lane_lo(L, DSIZE) +: DSIZE] = r_data[c_stages-1][L];
    end

endmodule

`default_nettype wire

// File: rtl/order_group_sort.sv
// ============================================================================
//  order_group_sort
//  Sorts every GROUP-lane slice of a LANES-wide beat; leftover lanes ride a
//  matching delay line. ORDER_GROUP_SORT_CNT_EN adds a 32-bit beat counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module order_group_sort
    import order_sort_pkg::*;
#(
    parameter int DSIZE = 64,
    parameter int KSIZE = 64,
    parameter int LANES = 25,
    parameter int GROUP = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hold,
    input  logic                     in_valid,
    input  logic                     in_desc,
    input  logic [LANES*DSIZE-1:0]   in_data,
    output logic                     out_valid,
    output logic                     out_desc,
    output logic [LANES*DSIZE-1:0]   out_data
`ifdef ORDER_GROUP_SORT_CNT_EN
    ,
    output logic [31:0]              beat_cnt
`endif
);

    localparam int c_ng     = LANES / GROUP;
    localparam int c_nr     = LANES % GROUP;
    localparam int c_stages = stages(GROUP);

    logic [c_ng-1:0] w_grp_valid;
    logic [c_ng-1:0] w_grp_desc;

    for (genvar G = 0; G < c_ng; G++) begin : g_grp
        order_group_sorter #(
            .DSIZE (DSIZE),
            .KSIZE (KSIZE),
            .GROUP (GROUP)
        ) u_sorter (
            .clock     (clock),
            .reset     (reset),
            .hold      (hold),
            .in_valid  (in_valid),
            .in_desc   (in_desc),
            .in_data   (in_data[lane_lo(G * GROUP, DSIZE) +: GROUP * DSIZE]),
            .out_valid (w_grp_valid[G]),
            .out_desc  (w_grp_desc[G]),
            .out_data  (out_data[lane_lo(G * GROUP, DSIZE) +: GROUP * DSIZE])
        );
    end

    // Every group holds an identical copy of the valid/desc pipeline.
    assign out_valid = &w_grp_valid;
    assign out_desc  = |w_grp_desc;

    if (c_nr > 0) begin : g_rem
        logic [c_nr*DSIZE-1:0] r_rem [c_stages];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int s = 0; s < c_stages; s++) begin
                    r_rem[s] <= '0;
                end
            end else if (!hold) begin
                r_rem[0] <= in_data[lane_lo(c_ng * GROUP, DSIZE) +: c_nr * DSIZE];
                for (int s = 1; s < c_stages; s++) begin
                    r_rem[s] <= r_rem[s-1];
                end
            end
        end

        assign out_data[lane_lo(c_ng * GROUP, DSIZE) +: c_nr * DSIZE] = r_rem[c_stages-1];
    end

`ifdef ORDER_GROUP_SORT_CNT_EN
    logic [31:0] r_beat_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_beat_cnt <= '0;
        end else if (!hold && out_valid) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_order_group_sort.sv
// ============================================================================
//  tb_order_group_sort
//  Scoreboard bench driving a 25x64 / group-4 instance and a 20x16 / group-8
//  instance (8-bit keys) from the same control stream.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_order_group_sort;

    localparam int A_D = 64, A_K = 64, A_L = 25, A_G = 4, A_LAT = 3;
    localparam int B_D = 16, B_K = 8,  B_L = 20, B_G = 8, B_LAT = 6;

    typedef logic [63:0] word_t;
    typedef struct packed {
        logic [31:0]   t;
        logic          desc;
        logic          exact;
        logic [1599:0] win;
        logic [1599:0] wexp;
    } beat_t;

    logic clock = 1'b0;
    logic reset, hold, in_valid, in_desc;
    logic [A_L*A_D-1:0] a_in, a_out, a_prev;
    logic [B_L*B_D-1:0] b_in, b_out, b_prev;
    logic a_ov, a_od, b_ov, b_od;
    logic a_ov_prev, a_od_prev, b_ov_prev, b_od_prev;
`ifdef ORDER_GROUP_SORT_CNT_EN
    logic [31:0] a_cnt, b_cnt;
`endif

    beat_t q_a[$];
    beat_t q_b[$];
    int    errors = 0;
    int    checks = 0;
    int    adv = 0;
    int    pops_a = 0, pops_b = 0;
    logic  live_q = 1'b0;
    logic  rst_q = 1'b1;

    order_group_sort #(.DSIZE(A_D), .KSIZE(A_K), .LANES(A_L), .GROUP(A_G)) u_dut_a (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_desc   (in_desc),
        .in_data   (a_in),
        .out_valid (a_ov),
        .out_desc  (a_od),
        .out_data  (a_out)
`ifdef ORDER_GROUP_SORT_CNT_EN
        ,
        .beat_cnt  (a_cnt)
`endif
    );

    order_group_sort #(.DSIZE(B_D), .KSIZE(B_K), .LANES(B_L), .GROUP(B_G)) u_dut_b (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_desc   (in_desc),
        .in_data   (b_in),
        .out_valid (b_ov),
        .out_desc  (b_od),
        .out_data  (b_out)
`ifdef ORDER_GROUP_SORT_CNT_EN
        ,
        .beat_cnt  (b_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t key_of(input word_t w, input int dsz, input int ksz);
        word_t k;
        k = w >> (dsz - ksz);
        if (ksz < 64) k = k & ((64'd1 << ksz) - 64'd1);
        return k;
    endfunction

    function automatic logic misordered(input word_t prev, input word_t cur,
                                        input int dsz, input int ksz, input logic desc);
        if (desc) return key_of(prev, dsz, ksz) < key_of(cur, dsz, ksz);
        return key_of(prev, dsz, ksz) > key_of(cur, dsz, ksz);
    endfunction

    // Reference: stable insertion sort per group; remainder lanes untouched.
    function automatic logic [1599:0] model(input logic [1599:0] win, input int lanes,
                                            input int grp, input int dsz, input int ksz,
                                            input logic desc);
        word_t w [25];
        word_t cur;
        int j;
        logic [1599:0] r;
        for (int l = 0; l < 25; l++) w[l] = win[l*64 +: 64];
        for (int b = 0; b + grp <= lanes; b += grp) begin
            for (int i = 1; i < grp; i++) begin
                cur = w[b+i];
                j = i;
                while (j > 0 && misordered(w[b+j-1], cur, dsz, ksz, desc)) begin
                    w[b+j] = w[b+j-1];
                    j--;
                end
                w[b+j] = cur;
            end
        end
        r = '0;
        for (int l = 0; l < 25; l++) r[l*64 +: 64] = w[l];
        return r;
    endfunction

    function automatic logic [1023:0] sort_full(input logic [1599:0] src, input int base, input int n);
        word_t w [16];
        word_t cur;
        int j;
        logic [1023:0] r;
        for (int i = 0; i < n; i++) w[i] = src[(base+i)*64 +: 64];
        for (int i = 1; i < n; i++) begin
            cur = w[i];
            j = i;
            while (j > 0 && w[j-1] > cur) begin
                w[j] = w[j-1];
                j--;
            end
            w[j] = cur;
        end
        r = '0;
        for (int i = 0; i < n; i++) r[i*64 +: 64] = w[i];
        return r;
    endfunction

    function automatic logic [1599:0] widen_b(input logic [B_L*B_D-1:0] d);
        logic [1599:0] r;
        r = '0;
        for (int l = 0; l < B_L; l++) r[l*64 +: 64] = {48'd0, d[l*B_D +: B_D]};
        return r;
    endfunction

    function automatic logic [A_L*A_D-1:0] rand_a();
        logic [A_L*A_D-1:0] r;
        for (int l = 0; l < A_L; l++)
            r[l*64 +: 64] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7))
                                                         : {$urandom, $urandom};
        return r;
    endfunction

    function automatic logic [B_L*B_D-1:0] rand_b();
        logic [B_L*B_D-1:0] r;
        for (int l = 0; l < B_L; l++)
            r[l*16 +: 16] = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
        return r;
    endfunction

    task automatic step(input logic v, input logic d, input logic h, input logic r,
                        input logic [A_L*A_D-1:0] ad, input logic [B_L*B_D-1:0] bd,
                        input logic exa, input logic exb);
        beat_t e;
        @(negedge clock);
        reset = r; hold = h; in_valid = v; in_desc = d; a_in = ad; b_in = bd;
        if (v && !h && !r) begin
            e.t = 32'(adv); e.desc = d;
            e.exact = exa; e.win = ad;
            e.wexp = model(e.win, A_L, A_G, A_D, A_K, d);
            q_a.push_back(e);
            e.exact = exb; e.win = widen_b(bd);
            e.wexp = model(e.win, B_L, B_G, B_D, B_K, d);
            q_b.push_back(e);
        end
    endtask

    task automatic score(input int which, input logic [1599:0] o, input logic od);
        beat_t e;
        int lanes, grp, dsz, ksz, lat, nsort;
        string p;
        logic [1023:0] s_out, s_in;
        if (which == 0) begin
            lanes = A_L; grp = A_G; dsz = A_D; ksz = A_K; lat = A_LAT; p = "a";
            if (q_a.size() == 0) begin check("a_unexpected_beat", 64'd1, 64'd0); return; end
            e = q_a.pop_front();
            pops_a++;
        end else begin
            lanes = B_L; grp = B_G; dsz = B_D; ksz = B_K; lat = B_LAT; p = "b";
            if (q_b.size() == 0) begin check("b_unexpected_beat", 64'd1, 64'd0); return; end
            e = q_b.pop_front();
            pops_b++;
        end
        nsort = (lanes / grp) * grp;
        check({p, "_latency"}, 64'(adv - int'(e.t)), 64'(lat));
        check({p, "_desc"}, 64'(od), 64'(e.desc));
        for (int l = 0; l < lanes; l++) begin
            if (l >= nsort || e.exact)
                check($sformatf("%s_lane%0d", p, l), o[l*64 +: 64], e.wexp[l*64 +: 64]);
            else
                check($sformatf("%s_key%0d", p, l), key_of(o[l*64 +: 64], dsz, ksz),
                      key_of(e.wexp[l*64 +: 64], dsz, ksz));
        end
        if (!e.exact) begin
            for (int b = 0; b < nsort; b += grp) begin
                s_out = sort_full(o, b, grp);
                s_in  = sort_full(e.win, b, grp);
                for (int i = 0; i < grp; i++)
                    check($sformatf("%s_words_g%0d", p, b / grp), s_out[i*64 +: 64], s_in[i*64 +: 64]);
            end
        end
    endtask

    always @(posedge clock) begin
        live_q <= !hold && !reset;
        rst_q  <= reset;
        if (!hold && !reset) adv <= adv + 1;
    end

    always @(negedge clock) begin
        if (live_q) begin
            if (a_ov) score(0, a_out, a_od);
            if (b_ov) score(1, widen_b(b_out), b_od);
        end else if (!rst_q) begin
            check("a_hold_stable", 64'((a_out == a_prev) && (a_ov == a_ov_prev) && (a_od == a_od_prev)), 64'd1);
            check("b_hold_stable", 64'((b_out == b_prev) && (b_ov == b_ov_prev) && (b_od == b_od_prev)), 64'd1);
        end
        a_prev = a_out; a_ov_prev = a_ov; a_od_prev = a_od;
        b_prev = b_out; b_ov_prev = b_ov; b_od_prev = b_od;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [A_L*A_D-1:0] ad;
        logic [B_L*B_D-1:0] bd;
        reset = 1'b1; hold = 1'b0; in_valid = 1'b0; in_desc = 1'b0;
        a_in = '0; b_in = '0;
        @(posedge clock); #1;
        check("rst_valid_a", 64'(a_ov), 64'd0);
        check("rst_desc_a",  64'(a_od), 64'd0);
        check("rst_data_a",  64'(a_out != '0), 64'd0);
        check("rst_valid_b", 64'(b_ov), 64'd0);
        check("rst_data_b",  64'(b_out != '0), 64'd0);
        step(0, 0, 0, 1, '0, '0, 1, 1);

        // Group0 keys {9,3,7,1}, ascending then descending, then back-to-back
        ad = rand_a();
        ad[0 +: 64] = 64'd9; ad[64 +: 64] = 64'd3; ad[128 +: 64] = 64'd7; ad[192 +: 64] = 64'd1;
        ad[24*64 +: 64] = 64'hDEAD_BEEF_0123_4567;
        step(1, 0, 0, 0, ad, rand_b(), 1, 0);
        repeat (8) step(0, 0, 0, 0, rand_a(), rand_b(), 1, 0);
        step(1, 1, 0, 0, ad, rand_b(), 1, 0);
        step(1, 0, 0, 0, ad, rand_b(), 1, 0);
        repeat (8) step(0, 0, 0, 0, rand_a(), rand_b(), 1, 0);

        // Stall two cycles mid-pipeline, pulsing in_valid while held
        step(1, 0, 0, 0, ad, rand_b(), 1, 0);
        step(0, 0, 0, 0, rand_a(), rand_b(), 1, 0);
        step(1, 1, 1, 0, rand_a(), rand_b(), 1, 0);
        step(1, 0, 1, 0, rand_a(), rand_b(), 1, 0);
        repeat (8) step(0, 0, 0, 0, rand_a(), rand_b(), 1, 0);

        // All-equal keys with distinct payloads stay in place in both directions
        bd = rand_b();
        for (int l = 0; l < 8; l++) bd[l*16 +: 16] = {8'h05, 8'(l * 8'h11)};
        for (int l = 8; l < 16; l++) bd[l*16 +: 16] = {8'h0A, 8'(l)};
        step(1, 0, 0, 0, {A_L{$urandom, $urandom}}, bd, 1, 1);
        step(1, 1, 0, 0, {A_L{$urandom, $urandom}}, bd, 1, 1);
        repeat (8) step(0, 0, 0, 0, rand_a(), rand_b(), 1, 0);

        for (int i = 0; i < 1000; i++)
            step($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                 0, rand_a(), rand_b(), 0, 0);
        repeat (8) step(0, 0, 0, 0, rand_a(), rand_b(), 0, 0);

`ifdef ORDER_GROUP_SORT_CNT_EN
        check("cnt_a", 64'(a_cnt), 64'(pops_a));
        check("cnt_b", 64'(b_cnt), 64'(pops_b));
`endif

        // Reset (together with hold) while beats are in flight
        repeat (3) step(1, 1'($urandom_range(0, 1)), 0, 0, rand_a(), rand_b(), 0, 0);
        step(0, 0, 1, 1, rand_a(), rand_b(), 0, 0);
        @(posedge clock); #1;
        q_a.delete(); q_b.delete();
        pops_a = 0; pops_b = 0;
        check("midrst_valid_a", 64'(a_ov), 64'd0);
        check("midrst_data_a",  64'(a_out != '0), 64'd0);
        check("midrst_valid_b", 64'(b_ov), 64'd0);
        check("midrst_data_b",  64'(b_out != '0), 64'd0);
`ifdef ORDER_GROUP_SORT_CNT_EN
        check("midrst_cnt_a", 64'(a_cnt), 64'd0);
        check("midrst_cnt_b", 64'(b_cnt), 64'd0);
`endif
        step(1, 0, 0, 0, ad, rand_b(), 1, 0);
        for (int i = 0; i < 40 && (q_a.size() != 0 || q_b.size() != 0); i++)
            step(0, 0, 0, 0, rand_a(), rand_b(), 1, 0);
        repeat (8) step(0, 0, 0, 0, rand_a(), rand_b(), 1, 0);
        check("drain_a", 64'(q_a.size()), 64'd0);
        check("drain_b", 64'(q_b.size()), 64'd0);
`ifdef ORDER_GROUP_SORT_CNT_EN
        check("cnt_post_a", 64'(a_cnt), 64'(pops_a));
        check("cnt_post_b", 64'(b_cnt), 64'(pops_b));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
